stream_burst_source: RTL and testbench
======================================

# stream_burst_source

Valid/ready stream producer that generates one burst of incrementing data beats per command and drives it into a downstream ingress port, such as the skid buffer's `i_valid_i`/`i_data_i`/`i_ready_o`. It is the transmit end of the team's 8-bit valid/ready interface. Backpressure handling is strict: data and valid stay stable while stalled, and valid never drops before acceptance. It also serves as the stimulus source for buffer and pipeline stages under test.

## Interface
- `DATA_W`, default 8: beat data width.
- `LEN_W`, default 8: width of the burst length and beat counter.

- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `start_i` in 1: burst request; sampled only in IDLE.
- `len_i` in LEN_W: number of beats in the burst; sampled with `start_i`.
- `seed_i` in DATA_W: value of the first beat; sampled with `start_i`.
- `gap_en_i` in 1: when 1, insert one idle cycle after each accepted non-final beat.
- `e_ready_i` in 1: downstream ready.
- `e_valid_o` out 1: beat valid.
- `e_data_o` out DATA_W: beat data.
- `e_last_o` out 1: marks the final beat of the burst.
- `busy_o` out 1: high whenever state is not IDLE.
- `done_o` out 1: single-cycle pulse after the final handshake.
- `beat_cnt_o` out LEN_W: number of beats accepted in the current or most recent burst.

## Operation
- Handshake: a beat transfers on a rising edge where `e_valid_o && e_ready_i`.
- While `e_valid_o=1` and `e_ready_i=0`:
  - `e_valid_o`, `e_data_o` and `e_last_o` hold unchanged.
  - Valid is never withdrawn before acceptance.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE:
    - `start_i=1`, `len_i!=0`: latch `remaining=len_i`, `data=seed_i`, clear `beat_cnt_o`, go to SEND.
    - `start_i=1`, `len_i=0`: clear `beat_cnt_o`, go to DONE; no beat is emitted.
    - Otherwise stay in IDLE.
  - SEND: `e_valid_o=1`. On handshake: `beat_cnt_o+1`, `data+1`, `remaining-1`.
    - If the beat was the last one (`remaining==1`), go to DONE.
    - Else if `gap_en_i=1`, go to GAP.
    - Else stay in SEND.
    - With no handshake, stay in SEND and hold.
  - GAP: `e_valid_o=0`; unconditionally return to SEND next cycle.
  - DONE: `done_o=1` for exactly this cycle; go to IDLE.
- Arithmetic:
  - `data` increments modulo 2^DATA_W, so 8'hFF is followed by 8'h00.
  - `beat_cnt_o` saturates at 2^LEN_W-1; this cannot occur for a legal `len_i`.
- `e_last_o = (state==SEND) && (remaining==1)`.
- `e_data_o` is a register; it is meaningful only while `e_valid_o=1`, and holds the next value otherwise.
- `start_i` outside IDLE is ignored, including in DONE; it is not queued.
- `len_i` and `seed_i` are ignored outside the start cycle.
- `gap_en_i` is sampled at each handshake, so it may change mid-burst.
- `beat_cnt_o` holds its final value through IDLE until the next accepted start.

## Timing
- Reset (`reset_n=0`, asynchronous): state IDLE; `e_valid_o=0`, `e_last_o=0`, `busy_o=0`, `done_o=0`, `e_data_o=0`, `beat_cnt_o=0`, `remaining=0`.
- Reset mid-burst: `e_valid_o` drops immediately without waiting for a clock, and the burst is abandoned. After release, the block is in IDLE with no `done_o`.
- All outputs are decoded from registers only; there is no combinational path from `e_ready_i` or `start_i` to any output.
- Latency, with start sampled at edge k:
  - `e_valid_o` is high after edge k.
  - With `e_ready_i=1` and `gap_en_i=0`, N beats transfer on edges k+1..k+N.
  - `done_o` is high between edges k+N and k+N+1.
  - IDLE resumes after edge k+N+1, and the next start can be sampled at k+N+2.
- Throughput: one beat per cycle without gaps; one beat per two cycles with `gap_en_i=1` and ready held high.
- Every stalled cycle adds exactly one cycle to the burst.

## Test plan
- Basic burst: `seed_i=8'h10`, `len_i=4`, `e_ready_i=1`. Expect 10,11,12,13 on four consecutive cycles; `e_last_o` only with 13; `done_o` for one cycle; `beat_cnt_o=4`.
- Backpressure: `len_i=3`, `e_ready_i` pattern 0,0,1,0,1,1. Expect data held stable with valid high through every stall; beats accepted in order; `done_o` after the 6th cycle.
- Gap and wrap: `seed_i=8'hFE`, `len_i=3`, `gap_en_i=1`, ready high. Expect FE, idle, FF, idle, 00; `e_last_o` on 00.
- Zero length and ignored start: `len_i=0` gives `done_o` one cycle after start and no valid. A `start_i` pulse mid-burst does not change data, length or count.
- Async reset: assert `reset_n=0` between clock edges while stalled at beat 2 of 5. Expect `e_valid_o` to drop before the next edge, all outputs 0, and a clean burst on the next start.
- Back-to-back: two starts as early as allowed, `len_i=2` each. Expect two idle cycles between the last beat of burst 1 and the first beat of burst 2, and `beat_cnt_o` reloaded to 0 then 2.

Source files
------------

// File: rtl/stream_burst_source_if.sv
// Transmit-side valid/ready stream bundle for the 8-bit beat interface.
// The master drives valid/data/last, and the slave returns ready.
interface stream_burst_source_if #(
    parameter int DATA_W = 8
);
    logic              e_valid_o;
    logic [DATA_W-1:0] e_data_o;
    logic              e_last_o;
    logic              e_ready_i;

    modport master (
        output e_valid_o,
        output e_data_o,
        output e_last_o,
        input  e_ready_i
    );

    modport slave (
        input  e_valid_o,
        input  e_data_o,
        input  e_last_o,
        output e_ready_i
    );
endinterface

// File: rtl/stream_burst_source.sv
// Burst generator: each accepted start emits len incrementing beats from seed
// on a valid/ready stream, with optional one-cycle gaps between beats.
module stream_burst_source #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [DATA_W-1:0]     seed_i,
    input  logic                  gap_en_i,
    stream_burst_source_if.master e_bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_W-1:0]      beat_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r, state_next_s;
    logic [LEN_W-1:0]  remaining_r, remaining_next_s;
    logic [DATA_W-1:0] data_r, data_next_s;
    logic [LEN_W-1:0]  beat_cnt_r, beat_cnt_next_s;
    logic              handshake_s;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] value);
        if (value == {LEN_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + LEN_W'(1);
        end
    endfunction

    // Outputs are pure decodes of registered state, so reset drops valid at once.
    assign e_bus.e_valid_o = (state_r == SEND);
    assign e_bus.e_data_o  = data_r;
    assign e_bus.e_last_o  = (state_r == SEND) && (remaining_r == LEN_W'(1));
    assign busy_o          = (state_r != IDLE);
    assign done_o          = (state_r == DONE);
    assign beat_cnt_o      = beat_cnt_r;

    assign handshake_s = (state_r == SEND) && e_bus.e_ready_i;

    // Next-state and datapath update for the burst sequencer.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        data_next_s      = data_r;
        beat_cnt_next_s  = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    beat_cnt_next_s = {LEN_W{1'b0}};
                    if (len_i != {LEN_W{1'b0}}) begin
                        remaining_next_s = len_i;
                        data_next_s      = seed_i;
                        state_next_s     = SEND;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (handshake_s) begin
                    beat_cnt_next_s  = sat_inc(beat_cnt_r);
                    data_next_s      = data_r + DATA_W'(1);
                    remaining_next_s = remaining_r - LEN_W'(1);
                    if (remaining_r == LEN_W'(1)) begin
                        state_next_s = DONE;
                    end else if (gap_en_i) begin
                        state_next_s = GAP;
                    end else begin
                        state_next_s = SEND;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            GAP: begin
                state_next_s = SEND;
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            remaining_r <= {LEN_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            beat_cnt_r  <= {LEN_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
            data_r      <= data_next_s;
            beat_cnt_r  <= beat_cnt_next_s;
        end
    end

endmodule

// File: tb/tb_stream_burst_source.sv
// Directed table-driven bench for stream_burst_source, plus a hand-written
// asynchronous-reset sequence.
module tb_stream_burst_source;

    logic       clk;
    logic       reset_n;
    logic       start_i;
    logic [7:0] len_i;
    logic [7:0] seed_i;
    logic       gap_en_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] beat_cnt_o;

    int checks   = 0;
    int failures = 0;
    int row_id   = 0;

    stream_burst_source_if #(.DATA_W(8)) bus ();

    stream_burst_source #(.DATA_W(8), .LEN_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .len_i      (len_i),
        .seed_i     (seed_i),
        .gap_en_i   (gap_en_i),
        .e_bus      (bus.master),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .beat_cnt_o (beat_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic [7:0] seed;
        logic       gap;
        logic       ready;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       b;
        logic       dn;
        logic [7:0] c;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL row%0d %s actual=%0h required=%0h", row_id, nm, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [7:0] ln, input logic [7:0] sd,
                       input logic gp, input logic rdy, input logic v, input logic [7:0] d,
                       input logic l, input logic b, input logic dn, input logic [7:0] c);
        vec_t r;
        r.start = st; r.len = ln; r.seed = sd; r.gap = gp; r.ready = rdy;
        r.v = v; r.d = d; r.l = l; r.b = b; r.dn = dn; r.c = c;
        vecs.push_back(r);
    endtask

    task automatic check_outputs(input logic v, input logic [7:0] d, input logic l,
                                 input logic b, input logic dn, input logic [7:0] c);
        chk("valid", {31'd0, bus.e_valid_o}, {31'd0, v});
        if (v) chk("data", {24'd0, bus.e_data_o}, {24'd0, d});
        chk("last", {31'd0, bus.e_last_o}, {31'd0, l});
        chk("busy", {31'd0, busy_o}, {31'd0, b});
        chk("done", {31'd0, done_o}, {31'd0, dn});
        chk("beat_cnt", {24'd0, beat_cnt_o}, {24'd0, c});
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input vec_t r);
        start_i       = r.start;
        len_i         = r.len;
        seed_i        = r.seed;
        gap_en_i      = r.gap;
        bus.e_ready_i = r.ready;
        @(posedge clk);
        @(negedge clk);
        check_outputs(r.v, r.d, r.l, r.b, r.dn, r.c);
        row_id++;
    endtask

    initial begin
        vec_t h;
        reset_n = 1'b0; start_i = 1'b0; len_i = 8'd0; seed_i = 8'd0;
        gap_en_i = 1'b0; bus.e_ready_i = 1'b0;

        // Basic burst: 10,11,12,13 back to back
        add(1'b1, 8'd4, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'd0);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'd1);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'd2);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 8'd3);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd4);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd4);
        // Backpressure: ready 0,0,1,0,1,1 and a start pulse while stalled
        add(1'b1, 8'd3, 8'h40, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'd0);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'd0);
        add(1'b1, 8'd7, 8'h99, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'd0);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'd1);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'd1);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 8'd2);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd3);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd3);
        // Gap and wrap: FE, idle, FF, idle, 00
        add(1'b1, 8'd3, 8'hFE, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 8'd0);
        add(1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1);
        add(1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'd1);
        add(1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd2);
        add(1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'd2);
        add(1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd3);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd3);
        // Zero length: done next cycle, no valid, count cleared
        add(1'b1, 8'd0, 8'hAA, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
        // Back-to-back len 2; the start seen in DONE is dropped
        add(1'b1, 8'd2, 8'h20, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'd0);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 8'd1);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd2);
        add(1'b1, 8'd2, 8'h50, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2);
        add(1'b1, 8'd2, 8'h50, 1'b0, 1'b1, 1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 8'd0);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h51, 1'b1, 1'b1, 1'b0, 8'd1);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd2);
        add(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2);

        // Reset state
        #12;
        chk("rst_data", {24'd0, bus.e_data_o}, 32'd0);
        check_outputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Async reset while stalled on beat 2 of 5
        h = '{1'b1, 8'd5, 8'h30, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 8'd0};
        step(h);
        h = '{1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 8'd1};
        step(h);
        h = '{1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 8'd1};
        step(h);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_data", {24'd0, bus.e_data_o}, 32'd0);
        check_outputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
        row_id++;
        @(negedge clk);
        reset_n = 1'b1;
        h = '{1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
        step(h);
        h = '{1'b1, 8'd2, 8'h77, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'd0};
        step(h);
        h = '{1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h78, 1'b1, 1'b1, 1'b0, 8'd1};
        step(h);
        h = '{1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd2};
        step(h);
        h = '{1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2};
        step(h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
